muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit that owns the HI/LO registers for the next-generation MIPS core.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO registers (IDLE -> ITER -> FIX).
// Optional MADD/MSUB accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2, OP_DIVU = 3'd3,
    OP_MTHI  = 3'd4, OP_MTLO  = 3'd5, OP_MADD = 3'd6, OP_MSUB = 3'd7
  } op_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done, r_dz_pulse;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_up, r_lw, r_b;
  logic             r_is_div, r_neg_q, r_neg_r, r_dz;
`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] r_acc;
  logic               r_madd, r_msub;
`endif

  op_e              w_op;
  logic             w_is_mul, w_is_div, w_signed, w_idle_req, w_accept, w_b_zero;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum, w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH-1:0] w_prod, w_prod_s, w_mul_res;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

  // ---------------- request decode ----------------
  assign w_op     = op_e'(op);
`ifdef MULDIV_MADD_EN
  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                    (w_op == OP_MADD) || (w_op == OP_MSUB);
`else
  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
`endif
  assign w_is_div   = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_signed   = (w_op == OP_MULT) || (w_op == OP_DIV) ||
                      (w_op == OP_MADD) || (w_op == OP_MSUB);
  assign w_idle_req = (r_state == S_IDLE) && start && !cancel;
  assign w_accept   = w_idle_req && (w_is_mul || w_is_div);
  assign w_b_zero   = (b == '0);
  assign w_a_neg    = w_signed && a[WIDTH-1];
  assign w_b_neg    = w_signed && b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;

  // ---------------- iteration datapath ----------------
  // Multiply: {r_up,r_lw} is the shifting product/multiplier pair.
  // Divide:   r_up is the partial remainder, r_lw shifts dividend out and quotient in.
  assign w_sum    = {1'b0, r_up} + {1'b0, (r_lw[0] ? r_b : '0)};
  assign w_rem_sh = {r_up, r_lw[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_b;

  assign w_prod   = {r_up, r_lw};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_mul_res = w_prod_s;
`ifdef MULDIV_MADD_EN
    if (r_madd)      w_mul_res = r_acc + w_prod_s;
    else if (r_msub) w_mul_res = r_acc - w_prod_s;
`endif
  end

  always_comb begin
    w_fix_hi = w_mul_res[2*WIDTH-1:WIDTH];
    w_fix_lo = w_mul_res[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_fix_hi = r_up;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_r ? -r_up : r_up;
        w_fix_lo = r_neg_q ? -r_lw : r_lw;
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_is_div && w_b_zero) ? S_FIX : S_ITER;
      S_ITER: begin
        if (cancel)                           w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))     w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = r_done;
    div_zero = r_dz_pulse;
    hi       = r_hi;
    lo       = r_lo;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      r_cnt      <= '0;
      r_up       <= '0;
      r_lw       <= '0;
      r_b        <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
`ifdef MULDIV_MADD_EN
      r_acc      <= '0;
      r_madd     <= 1'b0;
      r_msub     <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      if (w_idle_req && (w_op == OP_MTHI)) r_hi <= a;
      if (w_idle_req && (w_op == OP_MTLO)) r_lo <= a;
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= w_is_div;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_dz     <= w_is_div && w_b_zero;
        r_b      <= w_is_div ? w_b_mag : w_a_mag;
        r_lw     <= w_is_div ? w_a_mag : w_b_mag;
        // divide-by-zero skips ITER; r_up carries raw a through to HI
        r_up     <= (w_is_div && w_b_zero) ? a : '0;
`ifdef MULDIV_MADD_EN
        r_acc    <= {r_hi, r_lo};
        r_madd   <= (w_op == OP_MADD);
        r_msub   <= (w_op == OP_MSUB);
`endif
      end
      if ((r_state == S_ITER) && !cancel) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_up <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
          r_lw <= {r_lw[WIDTH-2:0], w_ge};
        end else begin
          r_up <= w_sum[WIDTH:1];
          r_lw <= {w_sum[0], r_lw[WIDTH-1:1]};
        end
      end
      if ((r_state == S_FIX) && !cancel) begin
        r_hi       <= w_fix_hi;
        r_lo       <= w_fix_lo;
        r_done     <= 1'b1;
        r_dz_pulse <= r_dz;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32); MADD/MSUB checks follow MULDIV_MADD_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Cycle c = value sampled at edge E0+c (observed #1 after edge E0+c-1).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int done_cyc, output bit busy_ok, output bit busy_at_done,
                        output bit dz_at_done);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = 0; busy_ok = 1'b1; busy_at_done = 1'b0; dz_at_done = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        done_cyc = c; busy_at_done = busy; dz_at_done = div_zero;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
    op = o; a = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    n_checks++; if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero}); end
  endtask

  task automatic test_multu;
    int dc; bit bok, bad, dz;
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, dc, bok, bad, dz);
    n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL multu_latency: got %0d want 34", dc); end
    n_checks++; if (!bok || bad) begin
      n_fail++; $display("FAIL multu_busy: busy_ok=%0d busy_at_done=%0d want 1/0", bok, bad); end
    n_checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
      n_fail++; $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", hi, lo); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mult_divu;
    int dc; bit bok, bad, dz;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || dc !== 34) begin
      n_fail++; $display("FAIL mult_neg: got %h_%h cyc %0d want ffffffff_ffffffeb cyc 34", hi, lo, dc); end
    run_op(3'd3, 32'd7, 32'd2, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== {32'd1, 32'd3} || dc !== 34) begin
      n_fail++; $display("FAIL divu_7_2: got hi %h lo %h cyc %0d want 1 3 cyc 34", hi, lo, dc); end
  endtask

  task automatic test_div_signed;
    int dc; bit bok, bad, dz;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL div_neg7_2: got hi %h lo %h want ffffffff fffffffd", hi, lo); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000 || dz !== 1'b0) begin
      n_fail++; $display("FAIL div_overflow: got hi %h lo %h dz %b want 0 80000000 0", hi, lo, dz); end
    run_op(3'd2, 32'd100, 32'hFFFF_FFF9, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFF2) begin
      n_fail++; $display("FAIL div_100_neg7: got hi %h lo %h want 2 fffffff2", hi, lo); end
  endtask

  task automatic test_div_zero;
    int dc; bit bok, bad, dz;
    run_op(3'd2, 32'd5, 32'd0, dc, bok, bad, dz);
    n_checks++; if (dc !== 2 || dz !== 1'b1) begin
      n_fail++; $display("FAIL divzero_timing: got cyc %0d dz %b want cyc 2 dz 1", dc, dz); end
    n_checks++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin
      n_fail++; $display("FAIL divzero_result: got hi %h lo %h want 5 ffffffff", hi, lo); end
    run_op(3'd3, 32'd9, 32'd3, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== {32'd0, 32'd3} || dz !== 1'b0 || dc !== 34) begin
      n_fail++; $display("FAIL divu_9_3: got hi %h lo %h dz %b cyc %0d want 0 3 0 34", hi, lo, dz, dc); end
  endtask

  task automatic test_cancel;
    bit seen;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    run_mt(3'd4, 32'h0000_1234);
    n_checks++; if ({hi, lo, busy, done} !== {32'h1234, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL mthi: got hi %h lo %h busy %b done %b want 1234 0 0 0", hi, lo, busy, done); end
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_pre_busy: got %b want 1", busy); end
    cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: got %b want 0", seen); end
    n_checks++; if ({hi, lo} !== {32'h1234, 32'h0}) begin
      n_fail++; $display("FAIL cancel_hilo: got hi %h lo %h want 1234 0", hi, lo); end
    // cancel together with a start in IDLE drops the start
    op = 3'd1; a = 32'd2; b = 32'd2; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_with_start: busy got %b want 0", busy); end
  endtask

  task automatic test_capture_ignore;
    int dc; bit seen;
    op = 3'd1; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    a = 32'd100; b = 32'd7;
    dc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin dc = c; break; end
      start = (c == 5); op = 3'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_checks++; if (dc !== 34 || {hi, lo} !== {32'd0, 32'd30}) begin
      n_fail++; $display("FAIL capture_busy_start: got hi %h lo %h cyc %0d want 0 1e cyc 34", hi, lo, dc); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (busy) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL no_queue: busy got %b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int dc; bit bok, bad, dz;
    run_op(3'd1, 32'h0001_0000, 32'h0001_0000, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
      n_fail++; $display("FAIL b2b_first: got %h_%h want 00000001_00000000", hi, lo); end
    run_op(3'd0, 32'd6, 32'hFFFF_FFFE, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF4 || dc !== 34 || !bok) begin
      n_fail++; $display("FAIL b2b_second: got %h_%h cyc %0d busy_ok %0d want ffffffff_fffffff4 34 1", hi, lo, dc, bok); end
  endtask

  task automatic test_madd;
`ifdef MULDIV_MADD_EN
    int dc; bit bok, bad, dz;
    run_mt(3'd4, 32'h0);
    run_mt(3'd5, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd1, 32'd1, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'h0000_0001_0000_0000 || dc !== 34) begin
      n_fail++; $display("FAIL madd: got %h_%h cyc %0d want 00000001_00000000 34", hi, lo, dc); end
    run_op(3'd7, 32'd2, 32'd3, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFA) begin
      n_fail++; $display("FAIL msub: got %h_%h want 00000000_fffffffa", hi, lo); end
    run_op(3'd6, 32'hFFFF_FFFF, 32'd2, dc, bok, bad, dz);
    n_checks++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFF8) begin
      n_fail++; $display("FAIL madd_signed: got %h_%h want 00000000_fffffff8", hi, lo); end
`else
    bit seen;
    run_mt(3'd4, 32'hAA);
    run_mt(3'd5, 32'hBB);
    seen = 1'b0;
    for (int k = 6; k <= 7; k++) begin
      op = k[2:0]; a = 32'd1; b = 32'd1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (busy || done) seen = 1'b1;
        @(posedge clk); #1;
      end
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL madd_disabled_busy: got %b want 0", seen); end
    n_checks++; if ({hi, lo} !== {32'hAA, 32'hBB}) begin
      n_fail++; $display("FAIL madd_disabled_hilo: got hi %h lo %h want aa bb", hi, lo); end
`endif
  endtask

  task automatic test_reset_mid;
    bit seen;
    run_mt(3'd4, 32'h55);
    op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_checks++; if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid: got busy %b hi %h lo %h want 0 0 0", busy, hi, lo); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done: got %b want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult_divu;
    test_div_signed;
    test_div_zero;
    test_cancel;
    test_capture_ignore;
    test_back_to_back;
    test_madd;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
